// File: rtl/acpo_engine.sv
// acpo_engine: per-lane activation (optional ReLU), max-pooling and pooled-result buffering.
// Ports:
//   clk, rst            - single clock, synchronous active-high reset
//   start               - begin/restart a frame; latches cfg_relu / cfg_pool_win
//   in_valid/in_last    - per-lane sample strobe and end-of-frame marker
//   in_data/in_addr     - per-lane signed sample and its address tag (packed by lane)
//   rd_en/rd_lane/rd_idx- random-access readout request; answered next cycle on rd_*
//   lane_count          - entries written per lane (packed by lane)
//   busy/done           - frame running / frame complete
//   overflow/drop_idle  - sticky: write dropped on full bank / sample seen outside RUN
module acpo_engine #(
    parameter int unsigned LANES         = 16,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 10,
    parameter int unsigned DEPTH         = 64,
    parameter int unsigned POOL_MAX      = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   cfg_relu,
    input  logic [$clog2(POOL_MAX+1)-1:0]          cfg_pool_win,
    input  logic [LANES-1:0]                       in_valid,
    input  logic [LANES-1:0]                       in_last,
    input  logic [LANES*DATA_WIDTH-1:0]            in_data,
    input  logic [LANES*ADDRESS_WIDTH-1:0]         in_addr,
    input  logic                                   rd_en,
    input  logic [$clog2(LANES)-1:0]               rd_lane,
    input  logic [$clog2(DEPTH)-1:0]               rd_idx,
    output logic                                   rd_valid,
    output logic [DATA_WIDTH-1:0]                  rd_data,
    output logic [ADDRESS_WIDTH-1:0]               rd_addr,
    output logic [LANES*($clog2(DEPTH)+1)-1:0]     lane_count,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   overflow,
    output logic                                   drop_idle
);
    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned AW = ADDRESS_WIDTH;
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;
    localparam int unsigned PW = $clog2(POOL_MAX + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic          relu_q;
    logic [PW-1:0] win_q;
    logic [PW-1:0] cfg_win_c;
    logic [LANES-1:0] got_last;

    // stage A (activation) registers
    logic [LANES-1:0]        a_valid, a_last;
    logic signed [DW-1:0]    a_data [LANES];
    logic [AW-1:0]           a_addr [LANES];

    // stage B (pooling) window state and emitted result
    logic [PW-1:0]           b_cnt  [LANES];
    logic signed [DW-1:0]    b_max  [LANES];
    logic [AW-1:0]           b_tag  [LANES];
    logic [LANES-1:0]        e_valid;
    logic signed [DW-1:0]    e_data [LANES];
    logic [AW-1:0]           e_addr [LANES];

    logic [CW-1:0]           cnt_q  [LANES];
    logic [DW+AW-1:0]        bank   [LANES][DEPTH];

    logic [LANES-1:0]        accept_c, emit_c, wr_c;
    logic [PW-1:0]           nxt_cnt_c [LANES];
    logic signed [DW-1:0]    cur_max_c [LANES];
    logic [AW-1:0]           cur_tag_c [LANES];

    // window length: 0 behaves as 1, oversize clamps to POOL_MAX
    always_comb begin
        cfg_win_c = cfg_pool_win;
        if (cfg_pool_win == '0)
            cfg_win_c = PW'(1);
        else if (cfg_pool_win > PW'(POOL_MAX))
            cfg_win_c = PW'(POOL_MAX);
    end

    // per-lane accept, pooling update and write enables
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            accept_c[i]  = (state == RUN) && !start && in_valid[i] && !got_last[i];
            nxt_cnt_c[i] = b_cnt[i] + PW'(1);
            if (b_cnt[i] == '0) begin
                cur_max_c[i] = a_data[i];
                cur_tag_c[i] = a_addr[i];
            end else begin
                // strict compare: ties keep the earlier sample
                cur_max_c[i] = (a_data[i] > b_max[i]) ? a_data[i] : b_max[i];
                cur_tag_c[i] = b_tag[i];
            end
            emit_c[i] = a_valid[i] && ((nxt_cnt_c[i] == win_q) || a_last[i]);
            wr_c[i]   = e_valid[i] && !start && !rst && (cnt_q[i] != CW'(DEPTH));
        end
    end

    // next state: DONE once all lanes saw last and nothing remains beyond the final write
    always_comb begin
        state_nxt = state;
        if (start)
            state_nxt = RUN;
        else if ((state == RUN) && (&got_last) && !(|a_valid))
            state_nxt = DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            done  <= (state_nxt == DONE);
        end
    end

    // datapath: activation, pooling, pointer update and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            relu_q    <= 1'b0;
            win_q     <= PW'(1);
            overflow  <= 1'b0;
            drop_idle <= 1'b0;
            got_last  <= '0;
            a_valid   <= '0;
            a_last    <= '0;
            e_valid   <= '0;
            for (int i = 0; i < LANES; i++) begin
                a_data[i] <= '0;
                a_addr[i] <= '0;
                b_cnt[i]  <= '0;
                b_max[i]  <= '0;
                b_tag[i]  <= '0;
                e_data[i] <= '0;
                e_addr[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else if (start) begin
            relu_q    <= cfg_relu;
            win_q     <= cfg_win_c;
            overflow  <= 1'b0;
            drop_idle <= 1'b0;
            got_last  <= '0;
            a_valid   <= '0;
            e_valid   <= '0;
            for (int i = 0; i < LANES; i++) begin
                b_cnt[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            if ((state != RUN) && (|in_valid))
                drop_idle <= 1'b1;
            a_valid  <= accept_c;
            a_last   <= accept_c & in_last;
            got_last <= got_last | (accept_c & in_last);
            e_valid  <= emit_c;
            for (int i = 0; i < LANES; i++) begin
                if (accept_c[i]) begin
                    a_data[i] <= (relu_q && in_data[i*DW + DW - 1]) ? '0 : in_data[i*DW +: DW];
                    a_addr[i] <= in_addr[i*AW +: AW];
                end
                if (a_valid[i]) begin
                    e_data[i] <= cur_max_c[i];
                    e_addr[i] <= cur_tag_c[i];
                    if (emit_c[i]) begin
                        b_cnt[i] <= '0;
                    end else begin
                        b_cnt[i] <= nxt_cnt_c[i];
                        b_max[i] <= cur_max_c[i];
                        b_tag[i] <= cur_tag_c[i];
                    end
                end
                if (e_valid[i]) begin
                    if (cnt_q[i] != CW'(DEPTH))
                        cnt_q[i] <= cnt_q[i] + CW'(1);
                    else
                        overflow <= 1'b1;
                end
            end
        end
    end

    // bank storage: never cleared, only pointers reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_c[i])
                bank[i][cnt_q[i][IW-1:0]] <= {e_addr[i], e_data[i]};
        end
    end

    // readout: registered, read-before-write on a same-entry collision
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_addr  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                {rd_addr, rd_data} <= bank[rd_lane][rd_idx];
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++)
            lane_count[i*CW +: CW] = cnt_q[i];
    end

endmodule

// File: tb/tb_acpo_engine.sv
// tb_acpo_engine: randomized + directed frames against a list-based pooling model;
// readout responses are checked by a monitor popping an expectation queue.
module tb_acpo_engine;
    localparam int unsigned LANES    = 16;
    localparam int unsigned DW       = 8;
    localparam int unsigned AW       = 10;
    localparam int unsigned DEPTH    = 64;
    localparam int unsigned POOL_MAX = 4;
    localparam int unsigned LW       = $clog2(LANES);
    localparam int unsigned IW       = $clog2(DEPTH);
    localparam int unsigned CW       = IW + 1;
    localparam int unsigned PW       = $clog2(POOL_MAX + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, start, cfg_relu;
    logic [PW-1:0]        cfg_pool_win;
    logic [LANES-1:0]     in_valid, in_last;
    logic [LANES*DW-1:0]  in_data;
    logic [LANES*AW-1:0]  in_addr;
    logic                 rd_en;
    logic [LW-1:0]        rd_lane;
    logic [IW-1:0]        rd_idx;
    logic                 rd_valid;
    logic [DW-1:0]        rd_data;
    logic [AW-1:0]        rd_addr;
    logic [LANES*CW-1:0]  lane_count;
    logic                 busy, done, overflow, drop_idle;

    acpo_engine #(
        .LANES(LANES), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH), .POOL_MAX(POOL_MAX)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_relu(cfg_relu), .cfg_pool_win(cfg_pool_win),
        .in_valid(in_valid), .in_last(in_last), .in_data(in_data), .in_addr(in_addr),
        .rd_en(rd_en), .rd_lane(rd_lane), .rd_idx(rd_idx), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_addr(rd_addr), .lane_count(lane_count), .busy(busy),
        .done(done), .overflow(overflow), .drop_idle(drop_idle)
    );

    typedef struct { int data; int addr; } ent_t;
    typedef struct { int lane; int idx; int data; int addr; } rd_t;

    int   checks = 0;
    int   passes = 0;
    ent_t exp_bank [LANES][DEPTH];
    int   exp_cnt  [LANES];
    bit   exp_ovf;
    int   stim_d   [LANES][$];
    int   stim_a   [LANES][$];
    rd_t  rd_q[$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int eff_win(input int cfg);
        if (cfg == 0) return 1;
        if (cfg > POOL_MAX) return POOL_MAX;
        return cfg;
    endfunction

    function automatic int act(input bit relu, input int d);
        return (relu && d < 0) ? 0 : d;
    endfunction

    function automatic int lc(input int l);
        return int'(lane_count[l*CW +: CW]);
    endfunction

    // reference: chop each lane's accepted sample list into windows of win, max per window
    task automatic model_frame(input bit relu, input int win);
        exp_ovf = 0;
        for (int l = 0; l < LANES; l++) begin
            int n = stim_d[l].size();
            exp_cnt[l] = 0;
            for (int k = 0; k < n; k += win) begin
                int m = act(relu, stim_d[l][k]);
                int a = stim_a[l][k];
                for (int j = k + 1; j < k + win && j < n; j++)
                    if (act(relu, stim_d[l][j]) > m) m = act(relu, stim_d[l][j]);
                if (exp_cnt[l] < DEPTH) begin
                    exp_bank[l][exp_cnt[l]] = '{m, a};
                    exp_cnt[l]++;
                end else begin
                    exp_ovf = 1;
                end
            end
        end
    endtask

    task automatic clear_stim();
        for (int l = 0; l < LANES; l++) begin
            stim_d[l].delete();
            stim_a[l].delete();
        end
    endtask

    task automatic rand_stim(input int lo, input int hi);
        for (int l = 0; l < LANES; l++) begin
            int n = $urandom_range(hi, lo);
            for (int k = 0; k < n; k++) begin
                stim_d[l].push_back(int'($urandom_range(255, 0)) - 128);
                stim_a[l].push_back(int'($urandom_range(1023, 0)));
            end
        end
    endtask

    task automatic drive_frame(input bit relu, input int cfg, input bit gaps,
                               input bit send_last, input int junk_lane);
        int ptr [LANES];
        bit any;
        start = 1; cfg_relu = relu; cfg_pool_win = PW'(cfg);
        tick();
        start = 0;
        check("start_busy", busy, 1);
        check("start_clear_count", longint'(lane_count), 0);
        check("start_clear_ovf", overflow, 0);
        check("start_clear_drop", drop_idle, 0);
        model_frame(relu, eff_win(cfg));
        for (int l = 0; l < LANES; l++) ptr[l] = 0;
        forever begin
            any = 0;
            in_valid = '0; in_last = '0;
            for (int l = 0; l < LANES; l++) begin
                if (ptr[l] < stim_d[l].size()) begin
                    any = 1;
                    if (!gaps || $urandom_range(3, 0) != 0) begin
                        in_valid[l] = 1'b1;
                        in_data[l*DW +: DW] = DW'(stim_d[l][ptr[l]]);
                        in_addr[l*AW +: AW] = AW'(stim_a[l][ptr[l]]);
                        in_last[l] = send_last && (ptr[l] == stim_d[l].size() - 1);
                        ptr[l]++;
                    end
                end else if (l == junk_lane) begin
                    in_valid[l] = 1'b1;
                    in_data[l*DW +: DW] = DW'(85);
                    in_addr[l*AW +: AW] = AW'(999);
                end
            end
            if (!any) break;
            tick();
        end
        in_valid = '0; in_last = '0;
        if (send_last) begin
            tick();
            check("done_early", done, 0);
            check("busy_before_done", busy, 1);
            tick();
            check("done_at_3", done, 1);
            check("busy_after_done", busy, 0);
        end else begin
            repeat (4) tick();
            check("busy_no_last", busy, 1);
            check("done_no_last", done, 0);
        end
        for (int l = 0; l < LANES; l++)
            check($sformatf("lane_count%0d", l), lc(l), exp_cnt[l]);
        check("overflow", overflow, exp_ovf);
    endtask

    task automatic read_req(input int l, input int i, input int d, input int a);
        rd_en = 1; rd_lane = LW'(l); rd_idx = IW'(i);
        rd_q.push_back('{l, i, d, a});
        tick();
    endtask

    task automatic readback_all();
        for (int l = 0; l < LANES; l++)
            for (int i = 0; i < exp_cnt[l]; i++)
                read_req(l, i, exp_bank[l][i].data, exp_bank[l][i].addr);
        rd_en = 0;
        repeat (2) tick();
    endtask

    task automatic rd_monitor();
        forever begin
            @(negedge clk);
            if (rd_valid === 1'b1) begin
                if (rd_q.size() == 0) begin
                    check("rd_unexpected", 1, 0);
                end else begin
                    rd_t e = rd_q.pop_front();
                    check($sformatf("rd_data l%0d i%0d", e.lane, e.idx), $signed(rd_data), e.data);
                    check($sformatf("rd_addr l%0d i%0d", e.lane, e.idx), rd_addr, e.addr);
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_drop_idle"}, drop_idle, 0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_lane_count"}, longint'(lane_count), 0);
    endtask

    initial begin
        rst = 1; start = 0; cfg_relu = 0; cfg_pool_win = '0;
        in_valid = '0; in_last = '0; in_data = '0; in_addr = '0;
        rd_en = 0; rd_lane = '0; rd_idx = '0;
        fork rd_monitor(); join_none
        repeat (2) tick();
        rst = 0;
        check_reset_outputs("reset");

        // ReLU on, win 1: lane 0 gets -5, 7, 0
        clear_stim();
        stim_d[0] = '{-5, 7, 0}; stim_a[0] = '{10, 11, 12};
        for (int l = 1; l < LANES; l++) begin
            stim_d[l].push_back(int'($urandom_range(255, 0)) - 128);
            stim_a[l].push_back(l);
        end
        drive_frame(1, 1, 0, 1, -1);
        check("t1_count0", lc(0), 3);
        read_req(0, 0, 0, 10);
        read_req(0, 1, 7, 11);
        read_req(0, 2, 0, 12);
        readback_all();

        // ReLU off, win 2: partial window flushed on last
        clear_stim();
        rand_stim(1, 3);
        stim_d[3] = '{-4, -9, 6, 2, 1}; stim_a[3] = '{20, 21, 22, 23, 24};
        drive_frame(0, 2, 0, 1, -1);
        check("t2_count3", lc(3), 3);
        read_req(3, 0, -4, 20);
        read_req(3, 1, 6, 22);
        read_req(3, 2, 1, 24);
        readback_all();

        // sample while DONE is dropped and flagged
        in_valid[2] = 1'b1; in_data[2*DW +: DW] = DW'(33);
        tick();
        in_valid = '0;
        tick();
        check("drop_idle_set", drop_idle, 1);
        check("drop_idle_no_write", lc(2), exp_cnt[2]);

        // sample after last on lane 5 is ignored
        clear_stim();
        rand_stim(3, 3);
        stim_d[5] = '{17}; stim_a[5] = '{55};
        drive_frame(1, 1, 0, 1, 5);
        check("post_last_count5", lc(5), 1);
        check("post_last_drop", drop_idle, 0);
        readback_all();

        // overflow: DEPTH+2 samples per lane, frame left running
        clear_stim();
        rand_stim(DEPTH + 2, DEPTH + 2);
        drive_frame(1'($urandom_range(1, 0)), 1, 0, 0, -1);
        check("ovf_flag", overflow, 1);
        readback_all();

        // restart while RUN with win 3 (driver checks pointer/flag clearing)
        clear_stim();
        rand_stim(1, 10);
        drive_frame(0, 3, 1, 1, -1);
        readback_all();

        // random frames including window 0 and oversize clamping
        for (int f = 0; f < 4; f++) begin
            clear_stim();
            rand_stim(1, 12);
            drive_frame(1'($urandom_range(1, 0)), int'($urandom_range(7, 0)), 1, 1, -1);
            readback_all();
        end

        // reset one cycle after an input: nothing written
        start = 1; cfg_relu = 0; cfg_pool_win = PW'(1);
        tick();
        start = 0;
        in_valid[0] = 1'b1; in_data[DW-1:0] = DW'(9); in_addr[AW-1:0] = AW'(7);
        tick();
        in_valid = '0;
        rst = 1;
        tick();
        rst = 0;
        check_reset_outputs("midrst");
        repeat (3) tick();
        check("midrst_no_write", longint'(lane_count), 0);

        for (int k = 0; k < 10 && rd_q.size() != 0; k++) tick();
        check("rd_queue_drained", rd_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
